// File: rtl/axi_mst_read_pkg.sv
// axi_mst_read_pkg: shared FSM state type, AXI constants and size helper for the DDR read master.
package axi_mst_read_pkg;
    typedef enum logic [3:0] {INIT, TRIG, READ_REGS, INIT_ADDR, ROOM, ADDR, DATA, DRAIN, TRIG_END, END} state_t;
    localparam logic [2:0] AXI_PROT_DATA = 3'b010;
    function automatic logic [2:0] axsize(input int bytes);
        return 3'($clog2(bytes));
    endfunction
endpackage

// File: rtl/axi_mst_read_if.sv
// axi_mst_read_if: AXI4 read address/data channels plus the AXIS output stream of the read master.
interface axi_mst_read_if #(parameter int ID_WIDTH = 1, parameter int DATA_WIDTH = 64);
    logic [ID_WIDTH-1:0]     arid;
    logic [31:0]             araddr;
    logic [3:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arlock;
    logic [3:0]              arcache;
    logic [2:0]              arprot;
    logic [3:0]              arregion;
    logic [3:0]              arqos;
    logic                    arvalid;
    logic                    arready;
    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic                    tlast;
    logic                    tvalid;
    logic                    tready;
    modport master(
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arregion, arqos, arvalid, rready,
        output tdata, tstrb, tlast, tvalid,
        input  arready, rid, rdata, rresp, rlast, rvalid, tready
    );
    modport slave(
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arregion, arqos, arvalid, rready,
        input  tdata, tstrb, tlast, tvalid,
        output arready, rid, rdata, rresp, rlast, rvalid, tready
    );
endinterface

// File: rtl/axi_mst_read_fifo.sv
// axi_mst_read_fifo: sync FIFO of {tlast,data} with a registered output stage and free-entry count.
module axi_mst_read_fifo #(
    parameter int W     = 65,
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          ready,
    output logic          valid,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] free,
    output logic          idle
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    logic          pop;
    // Refill the output register whenever it is empty or being consumed this cycle.
    assign pop  = cnt != 0 && (!valid || ready);
    assign free = CW'(DEPTH) - cnt;
    assign idle = cnt == 0 && !valid;
    always_ff @(posedge clk)
        if (push) mem[wp] <= din;
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            wp    <= '0;
            rp    <= '0;
            cnt   <= '0;
            valid <= 1'b0;
            dout  <= '0;
        end else begin
            if (push) wp <= wp == AW'(DEPTH - 1) ? '0 : wp + 1'b1;
            if (pop) rp <= rp == AW'(DEPTH - 1) ? '0 : rp + 1'b1;
            cnt <= cnt + CW'(push) - CW'(pop);
            if (pop) begin
                dout  <= mem[rp];
                valid <= 1'b1;
            end else if (ready) valid <= 1'b0;
        end
endmodule

// File: rtl/synchronizer_n.sv
// synchronizer_n: N-flop resynchroniser for asynchronous level inputs.
module synchronizer_n #(parameter int N = 2) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);
    logic [N-1:0] s;
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) s <= '0;
        else s <= {s[N-2:0], d};
    assign q = s[N-1];
endmodule

// File: rtl/axi_mst_read.sv
// axi_mst_read: AXI4 INCR burst read master streaming DDR data to AXIS for bandwidth tests.
// Define AXI_MST_READ_RRESP_CHK_EN to add the sticky ERR_REG (bad rresp or burst-length error).
module axi_mst_read
    import axi_mst_read_pkg::*;
#(
    parameter int ID_WIDTH   = 1,
    parameter int DATA_WIDTH = 64,
    parameter int BURST_SIZE = 15,
    parameter int FIFO_DEPTH = 32
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        trigger,
    input  logic        START_REG,
    input  logic [31:0] ADDR_REG,
    input  logic [31:0] NBURST_REG,
    axi_mst_read_if.master bus
`ifdef AXI_MST_READ_RRESP_CHK_EN
    , output logic      ERR_REG
`endif
);
    localparam int          BEATS = BURST_SIZE + 1;
    localparam int          CW    = $clog2(FIFO_DEPTH + 1);
    localparam logic [31:0] BPB   = 32'(BEATS * DATA_WIDTH / 8);
    state_t          state;
    logic            start_s, trig_s, push, idle, len_err, arvalid, rready;
    logic [31:0]     araddr, base, nburst_r, cnt_nb;
    logic [3:0]      beat;
    logic [CW-1:0]   free;
    logic [DATA_WIDTH:0] fifo_out;
    synchronizer_n #(.N(2)) u_sync_start (.clk, .rstn, .d(START_REG), .q(start_s));
    synchronizer_n #(.N(2)) u_sync_trig (.clk, .rstn, .d(trigger), .q(trig_s));
    assign bus.arid     = '0;
    assign bus.araddr   = araddr;
    assign bus.arlen    = 4'(BURST_SIZE);
    assign bus.arsize   = axsize(DATA_WIDTH / 8);
    assign bus.arburst  = 2'b01;
    assign bus.arlock   = 1'b0;
    assign bus.arcache  = '0;
    assign bus.arprot   = AXI_PROT_DATA;
    assign bus.arregion = '0;
    assign bus.arqos    = '0;
    assign bus.arvalid  = arvalid;
    assign bus.rready   = rready;
    assign bus.tstrb    = '1;
    assign bus.tdata    = fifo_out[DATA_WIDTH-1:0];
    assign bus.tlast    = fifo_out[DATA_WIDTH];
    assign push         = bus.rvalid && rready;
    axi_mst_read_fifo #(.W(DATA_WIDTH + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk, .rstn, .push,
        .din({bus.rlast && cnt_nb + 32'd1 == nburst_r, bus.rdata}),
        .ready(bus.tready), .valid(bus.tvalid), .dout(fifo_out), .free, .idle
    );
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            state    <= INIT;
            araddr   <= '0;
            arvalid  <= 1'b0;
            rready   <= 1'b0;
            base     <= '0;
            nburst_r <= '0;
            cnt_nb   <= '0;
            beat     <= '0;
            len_err  <= 1'b0;
        end else
            case (state)
                INIT:      if (start_s) state <= TRIG;
                TRIG:      if (trig_s) state <= READ_REGS;
                READ_REGS: begin
                    base     <= ADDR_REG;
                    nburst_r <= NBURST_REG;
                    cnt_nb   <= '0;
                    len_err  <= 1'b0;
                    state    <= INIT_ADDR;
                end
                INIT_ADDR: begin
                    araddr <= base;
                    state  <= ROOM;
                end
                ROOM:
                    if (cnt_nb == nburst_r) state <= DRAIN;
                    else if (free >= CW'(BEATS)) begin
                        arvalid <= 1'b1;
                        state   <= ADDR;
                    end
                ADDR:
                    if (bus.arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        beat    <= '0;
                        state   <= DATA;
                    end
                // Length errors are only flagged; the burst still ends on the slave's rlast.
                DATA:
                    if (bus.rvalid) begin
                        beat    <= beat + 1'b1;
                        len_err <= len_err | (bus.rlast ? beat != 4'(BURST_SIZE) : beat == 4'(BURST_SIZE));
                        if (bus.rlast) begin
                            rready <= 1'b0;
                            cnt_nb <= cnt_nb + 32'd1;
                            araddr <= araddr + BPB;
                            state  <= ROOM;
                        end
                    end
                DRAIN:     if (idle) state <= TRIG_END;
                TRIG_END:  if (!trig_s) state <= END;
                END:       if (!start_s) state <= INIT;
                default:   state <= INIT;
            endcase
`ifdef AXI_MST_READ_RRESP_CHK_EN
    logic rresp_err, unused;
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) rresp_err <= 1'b0;
        else if (state == READ_REGS) rresp_err <= 1'b0;
        else if (push && bus.rresp != 2'b00) rresp_err <= 1'b1;
    assign ERR_REG = rresp_err | len_err;
    assign unused  = ^bus.rid;
`else
    logic unused;
    assign unused = ^{bus.rid, bus.rresp, len_err};
`endif
endmodule

// File: tb/tb_axi_mst_read.sv
// tb_axi_mst_read: directed bench with a negedge-driven AXI slave model and AXIS stream scoreboard.
module tb_axi_mst_read;
    import axi_mst_read_pkg::*;
    logic        clk = 0, rstn = 0, trigger = 0, start = 0;
    logic [31:0] addr_reg = 0, nburst_reg = 0;
`ifdef AXI_MST_READ_RRESP_CHK_EN
    logic        err_reg;
`endif
    axi_mst_read_if #(.ID_WIDTH(1), .DATA_WIDTH(64)) bus ();
    axi_mst_read #(.ID_WIDTH(1), .DATA_WIDTH(64), .BURST_SIZE(15), .FIFO_DEPTH(32)) dut (
        .clk, .rstn, .trigger, .START_REG(start), .ADDR_REG(addr_reg), .NBURST_REG(nburst_reg), .bus(bus)
`ifdef AXI_MST_READ_RRESP_CHK_EN
        , .ERR_REG(err_reg)
`endif
    );
    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mem(input logic [31:0] a);
        return {a ^ 32'hA5A5_0000, ~a};
    endfunction

    int          ar_delay = 0, rv_mod = 1, tr_mode = 0, err_burst = -1, err_beat = -1;
    logic        mon_en = 1, slave_clr = 0;
    logic [31:0] exp_base = 0;
    int          exp_nb = 0, beats_out = 0, ar_cnt = 0;
    logic [31:0] ar_log[$];
    logic [31:0] r_addr_q[$];
    int          r_beat = 0, r_bidx = 0, ar_wait = 0, cyc = 0;
    logic        ar_seen = 0;
    logic [31:0] ar_hold = 0;

    // Slave memory, AR acceptor and stream monitor; values driven here hold through the next posedge.
    initial begin
        bus.arready = 0; bus.rvalid = 0; bus.rlast = 0; bus.rresp = 0; bus.rid = 0; bus.rdata = 0; bus.tready = 1;
        forever begin
            @(negedge clk);
            cyc++;
            bus.rvalid = 0; bus.rlast = 0; bus.rresp = 0; bus.arready = 0;
            if (slave_clr) begin
                r_addr_q.delete();
                r_beat = 0; r_bidx = 0; ar_wait = 0; ar_seen = 0;
            end else begin
                if (r_addr_q.size() > 0 && $urandom_range(rv_mod - 1) == 0) begin
                    bus.rvalid = 1;
                    bus.rdata  = mem(r_addr_q[0] + 32'(r_beat * 8));
                    bus.rlast  = r_beat == 15;
                    bus.rresp  = (r_bidx == err_burst && r_beat == err_beat) ? 2'b10 : 2'b00;
                    if (bus.rready) begin
                        r_beat++;
                        if (r_beat == 16) begin
                            r_beat = 0;
                            r_bidx++;
                            void'(r_addr_q.pop_front());
                        end
                    end
                end
                if (bus.arvalid) begin
                    if (!ar_seen) begin
                        ar_seen = 1; ar_hold = bus.araddr; ar_wait = 0;
                        check("ar_room", 64'(dut.free >= 16), 1);
                    end
                    check("ar_stable", bus.araddr, ar_hold);
                    if (ar_wait >= ar_delay) begin
                        bus.arready = 1;
                        ar_log.push_back(bus.araddr);
                        r_addr_q.push_back(bus.araddr);
                        ar_seen = 0;
                        ar_cnt++;
                    end else ar_wait++;
                end else if (ar_seen) check("arvalid_held", 64'(bus.arvalid), 1);
            end
            bus.tready = tr_mode == 0 ? 1'b1 : (cyc % 4 == 0);
            if (mon_en && bus.tvalid && bus.tready) begin
                check("tdata", bus.tdata, mem(exp_base + 32'(beats_out * 8)));
                check("tlast", 64'(bus.tlast), 64'(beats_out == exp_nb * 16 - 1));
                beats_out++;
            end
        end
    end

    task automatic wait_state(input string tag, input state_t s, input int max);
        int n = 0;
        while (dut.state != s && n < max) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(dut.state), 64'(s));
    endtask

    task automatic arm(input logic [31:0] a, input int nb);
        addr_reg = a; nburst_reg = nb; exp_base = a; exp_nb = nb;
        beats_out = 0; ar_cnt = 0; r_bidx = 0;
        ar_log.delete();
        start = 1;
        wait_state("to_trig", TRIG, 20);
        trigger = 1;
    endtask

    task automatic finish_run(input int nb);
        wait_state("to_trig_end", TRIG_END, 5000);
        check("beats", beats_out, nb * 16);
        check("ar_count", ar_cnt, nb);
        trigger = 0;
        wait_state("to_end", END, 20);
        start = 0;
        wait_state("to_init", INIT, 20);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_arvalid", 64'(bus.arvalid), 0);
        check("rst_rready", 64'(bus.rready), 0);
        check("rst_tvalid", 64'(bus.tvalid), 0);
        check("rst_tlast", 64'(bus.tlast), 0);
        check("rst_araddr", bus.araddr, 0);
        check("rst_state", 64'(dut.state), 64'(INIT));
        check("arlen", bus.arlen, 15);
        check("arsize", bus.arsize, 3);
        check("arburst", bus.arburst, 1);
        check("arprot", bus.arprot, 2);
        check("arcache_qos", {bus.arcache, bus.arqos, bus.arregion, bus.arlock, bus.arid}, 0);
        check("tstrb", bus.tstrb, 8'hFF);
        rstn = 1;
        arm(32'h1000_0000, 4);
        finish_run(4);
        for (int i = 0; i < 4; i++) check("t1_araddr", ar_log[i], 32'h1000_0000 + 32'(i * 128));
        arm(32'h2000_0000, 0);
        finish_run(0);
        tr_mode = 1;
        arm(32'h3000_0000, 8);
        finish_run(8);
        tr_mode = 0;
        ar_delay = 10; rv_mod = 3;
        arm(32'h4000_0100, 3);
        finish_run(3);
        ar_delay = 0; rv_mod = 1;
        arm(32'hFFFF_FF80, 2);
        finish_run(2);
        check("t5_araddr0", ar_log[0], 32'hFFFF_FF80);
        check("t5_araddr1", ar_log[1], 32'h0000_0000);
`ifdef AXI_MST_READ_RRESP_CHK_EN
        err_burst = 1; err_beat = 4;
        arm(32'h5000_0000, 3);
        finish_run(3);
        check("err_set", 64'(err_reg), 1);
        err_burst = -1;
        arm(32'h5000_0000, 1);
        check("err_hold", 64'(err_reg), 1);
        wait_state("t6_addr", ADDR, 20);
        check("err_clear", 64'(err_reg), 0);
        finish_run(1);
`endif
        mon_en = 0;
        arm(32'h6000_0000, 4);
        wait_state("t6_data", DATA, 100);
        repeat (5) @(negedge clk);
        rstn = 0;
        #1;
        check("abort_arvalid", 64'(bus.arvalid), 0);
        check("abort_rready", 64'(bus.rready), 0);
        check("abort_tvalid", 64'(bus.tvalid), 0);
        check("abort_tlast", 64'(bus.tlast), 0);
        check("abort_araddr", bus.araddr, 0);
        check("abort_state", 64'(dut.state), 64'(INIT));
        slave_clr = 1; start = 0; trigger = 0;
        repeat (3) @(negedge clk);
        slave_clr = 0; rstn = 1; mon_en = 1;
        arm(32'h7000_0000, 1);
        finish_run(1);
        check("recover_araddr", ar_log[0], 32'h7000_0000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
